// File: rtl/dut_step_sequencer.sv
// One DUT step per H2C packet: gate intake, clock the DUT for N cycles, settle,
// strobe a C2H capture, then wait (with watchdog) for the C2H transfer.
module dut_step_sequencer #(
    parameter int CYC_WIDTH      = 16,
    parameter int SETTLE_CYCLES  = 0,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int STEP_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      h2c_pkt_done,
    input  logic                      c2h_done,
    input  logic [CYC_WIDTH-1:0]      cfg_step_cycles,
    input  logic                      err_clear,
    output logic                      ctrl_h2c_en,
    output logic                      dut_clk_en,
    output logic                      ctrl_c2h_capture,
    output logic                      busy,
    output logic [STEP_CNT_WIDTH-1:0] step_count,
    output logic                      err_unexpected,
    output logic                      err_timeout
);

    // state   | meaning
    // IDLE    | h2c intake open, waiting for a packet
    // RUN     | DUT clock enabled, run_cnt counts down the remaining cycles
    // SETTLE  | DUT clock stopped, settle_cnt counts down before capture
    // CAPTURE | single-cycle capture strobe to c2h
    // DRAIN   | waiting for c2h_done, watchdog counting down
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CYC_WIDTH-1:0]      CYC_ONE     = CYC_WIDTH'(1);
    localparam logic [3:0]                SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [WD_WIDTH-1:0]       WD_LOAD     = WD_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WD_WIDTH-1:0]       WD_ONE      = WD_WIDTH'(1);
    localparam logic [STEP_CNT_WIDTH-1:0] STEP_ONE    = STEP_CNT_WIDTH'(1);

    state_t                    state_q;
    logic [CYC_WIDTH-1:0]      run_cnt_q;
    logic [3:0]                settle_cnt_q;
    logic [WD_WIDTH-1:0]       wd_cnt_q;
    logic                      done_pend_q;
    logic                      h2c_en_q;
    logic                      clk_en_q;
    logic                      capture_q;
    logic                      busy_q;
    logic [STEP_CNT_WIDTH-1:0] step_q;
    logic                      err_unexp_q;
    logic                      err_to_q;

    logic [CYC_WIDTH-1:0] run_load_d;
    logic                 drain_done_d;
    logic                 unexp_set_d;
    logic                 timeout_set_d;

    always_comb begin
        run_load_d    = (cfg_step_cycles == '0) ? CYC_ONE : cfg_step_cycles;
        // A c2h_done seen during CAPTURE is remembered so DRAIN can exit at once.
        drain_done_d  = c2h_done | done_pend_q;
        unexp_set_d   = h2c_pkt_done && (state_q != S_IDLE);
        timeout_set_d = (state_q == S_DRAIN) && !drain_done_d && (wd_cnt_q == WD_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            run_cnt_q    <= '0;
            settle_cnt_q <= '0;
            wd_cnt_q     <= '0;
            done_pend_q  <= 1'b0;
            h2c_en_q     <= 1'b1;
            clk_en_q     <= 1'b0;
            capture_q    <= 1'b0;
            busy_q       <= 1'b0;
            step_q       <= '0;
            err_unexp_q  <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            if (unexp_set_d) begin
                err_unexp_q <= 1'b1;
            end else if (err_clear) begin
                err_unexp_q <= 1'b0;
            end
            if (timeout_set_d) begin
                err_to_q <= 1'b1;
            end else if (err_clear) begin
                err_to_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (h2c_pkt_done) begin
                        run_cnt_q <= run_load_d;
                        state_q   <= S_RUN;
                        h2c_en_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        clk_en_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    run_cnt_q <= run_cnt_q - CYC_ONE;
                    if (run_cnt_q == CYC_ONE) begin
                        clk_en_q <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            state_q   <= S_CAPTURE;
                            capture_q <= 1'b1;
                        end else begin
                            state_q      <= S_SETTLE;
                            settle_cnt_q <= SETTLE_LOAD;
                        end
                    end
                end
                S_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q - 4'd1;
                    if (settle_cnt_q == 4'd1) begin
                        state_q   <= S_CAPTURE;
                        capture_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    capture_q   <= 1'b0;
                    state_q     <= S_DRAIN;
                    wd_cnt_q    <= WD_LOAD;
                    done_pend_q <= c2h_done;
                end
                S_DRAIN: begin
                    if (drain_done_d) begin
                        state_q     <= S_IDLE;
                        h2c_en_q    <= 1'b1;
                        busy_q      <= 1'b0;
                        done_pend_q <= 1'b0;
                        step_q      <= step_q + STEP_ONE;
                    end else if (wd_cnt_q == WD_ONE) begin
                        state_q     <= S_IDLE;
                        h2c_en_q    <= 1'b1;
                        busy_q      <= 1'b0;
                        done_pend_q <= 1'b0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q - WD_ONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    h2c_en_q    <= 1'b1;
                    busy_q      <= 1'b0;
                    clk_en_q    <= 1'b0;
                    capture_q   <= 1'b0;
                    done_pend_q <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_h2c_en      = h2c_en_q;
    assign dut_clk_en       = clk_en_q;
    assign ctrl_c2h_capture = capture_q;
    assign busy             = busy_q;
    assign step_count       = step_q;
    assign err_unexpected   = err_unexp_q;
    assign err_timeout      = err_to_q;

endmodule

// File: tb/tb_dut_step_sequencer.sv
// Random-stimulus bench for dut_step_sequencer: two instances (no settle with a
// narrow step counter, and a 2-cycle settle) checked every cycle against a timeline model.
module tb_dut_step_sequencer;

    localparam int T_OUT = 16;
    localparam int SET_C [2] = '{0, 2};
    localparam int STEP_W[2] = '{4, 32};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt   = 1'b0;
    logic        done  = 1'b0;
    logic        clr   = 1'b0;
    logic [15:0] cfg   = 16'd1;

    logic        ce     [2];
    logic        cap    [2];
    logic        h2c_en [2];
    logic        bsy    [2];
    logic        eu     [2];
    logic        et     [2];
    logic [3:0]  step0;
    logic [31:0] step1;

    int checks = 0;
    int errors = 0;

    // Timeline model: per instance, the accept edge and length fix every later event.
    int     cyc       = 0;
    bit     m_busy[2] = '{0, 0};
    int     m_t0  [2] = '{0, 0};
    int     m_n   [2] = '{0, 0};
    bit     m_pend[2] = '{0, 0};
    longint m_step[2] = '{0, 0};
    bit     m_eu  [2] = '{0, 0};
    bit     m_et  [2] = '{0, 0};

    always #5 clk = ~clk;

    dut_step_sequencer #(
        .CYC_WIDTH(16), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(T_OUT), .STEP_CNT_WIDTH(4)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .h2c_pkt_done(pkt), .c2h_done(done),
        .cfg_step_cycles(cfg), .err_clear(clr),
        .ctrl_h2c_en(h2c_en[0]), .dut_clk_en(ce[0]), .ctrl_c2h_capture(cap[0]),
        .busy(bsy[0]), .step_count(step0), .err_unexpected(eu[0]), .err_timeout(et[0])
    );

    dut_step_sequencer #(
        .CYC_WIDTH(16), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(T_OUT), .STEP_CNT_WIDTH(32)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .h2c_pkt_done(pkt), .c2h_done(done),
        .cfg_step_cycles(cfg), .err_clear(clr),
        .ctrl_h2c_en(h2c_en[1]), .dut_clk_en(ce[1]), .ctrl_c2h_capture(cap[1]),
        .busy(bsy[1]), .step_count(step1), .err_unexpected(eu[1]), .err_timeout(et[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_pend[k] = 0; m_step[k] = 0; m_eu[k] = 0; m_et[k] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                bit set_u, set_t;
                int c;
                set_u = 0;
                set_t = 0;
                if (!m_busy[k]) begin
                    if (pkt) begin
                        m_busy[k] = 1;
                        m_t0[k]   = cyc;
                        m_n[k]    = (cfg == 0) ? 1 : int'(cfg);
                        m_pend[k] = 0;
                    end
                end else begin
                    c = m_t0[k] + m_n[k] + SET_C[k] + 1;
                    if (pkt) set_u = 1;
                    if (cyc == c && done) m_pend[k] = 1;
                    if (cyc > c && cyc <= c + T_OUT) begin
                        if (done || m_pend[k]) begin
                            m_busy[k] = 0;
                            m_step[k] = (m_step[k] + 1) & ((64'd1 << STEP_W[k]) - 1);
                        end else if (cyc == c + T_OUT) begin
                            m_busy[k] = 0;
                            set_t = 1;
                        end
                    end
                end
                if (set_u) m_eu[k] = 1; else if (clr) m_eu[k] = 0;
                if (set_t) m_et[k] = 1; else if (clr) m_et[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  c;
            bit  e_ce, e_cap;
            c     = cyc + 1;
            e_ce  = m_busy[k] && (c >= m_t0[k] + 1) && (c <= m_t0[k] + m_n[k]);
            e_cap = m_busy[k] && (c == m_t0[k] + m_n[k] + SET_C[k] + 1);
            chk($sformatf("ce%0d", k),     64'(ce[k]),      64'(e_ce));
            chk($sformatf("cap%0d", k),    64'(cap[k]),     64'(e_cap));
            chk($sformatf("h2c_en%0d", k), 64'(h2c_en[k]),  64'(!m_busy[k]));
            chk($sformatf("busy%0d", k),   64'(bsy[k]),     64'(m_busy[k]));
            chk($sformatf("err_u%0d", k),  64'(eu[k]),      64'(m_eu[k]));
            chk($sformatf("err_t%0d", k),  64'(et[k]),      64'(m_et[k]));
            chk($sformatf("ce_cap_excl%0d", k), 64'(ce[k] & cap[k]), 64'd0);
        end
        chk("step0", 64'(step0), 64'(m_step[0]));
        chk("step1", 64'(step1), 64'(m_step[1]));
    end

    task automatic drive_random(input int cycles, input int pkt_pct, input int done_pct,
                                input int clr_pct);
        repeat (cycles) begin
            int r;
            @(negedge clk);
            #1;
            pkt  = ($urandom_range(0, 99) < pkt_pct);
            done = ($urandom_range(0, 99) < done_pct);
            clr  = ($urandom_range(0, 99) < clr_pct);
            r    = $urandom_range(0, 99);
            if (r < 20)      cfg = 16'd0;
            else if (r < 95) cfg = 16'($urandom_range(1, 6));
            else             cfg = 16'($urandom_range(7, 30));
        end
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        drive_random(2000, 15, 20, 3);
        drive_random(800, 30, 1, 2);
        drive_random(800, 10, 25, 3);

        // Bring the settle instance to idle, start a long step, reset in the middle of RUN.
        waited = 0;
        @(negedge clk);
        #1;
        pkt  = 1'b0;
        done = 1'b1;
        clr  = 1'b0;
        while ((m_busy[0] || m_busy[1]) && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("idle_wait", 64'(m_busy[0] || m_busy[1]), 64'd0);
        done = 1'b0;
        cfg  = 16'd10;
        pkt  = 1'b1;
        @(negedge clk);
        #1;
        pkt = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("ce_before_rst", 64'(ce[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ce_async_rst", 64'(ce[1]), 64'd0);
        chk("cap_async_rst", 64'(cap[1]), 64'd0);
        chk("h2c_en_async_rst", 64'(h2c_en[1]), 64'd1);
        chk("step_async_rst", 64'(step1), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        drive_random(800, 15, 20, 3);

        @(negedge clk);
        #1;
        pkt  = 1'b0;
        done = 1'b0;
        clr  = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
